gate_truth_sequencer: RTL and testbench

Self-checking truth-table sequencer for a small combinational gate under test (GUT) on the board. On a start request it drives every input vector to the GUT in order, holds each for a programmable settle time, samples the GUT output once per vector against an expected truth table, and reports pass/fail. It also drives the board LED, dimmed on pass and blinking on fail. It sits between the board buttons/clock and the gate module being brought up, replacing hand-probing with buttons.

---
 rtl/gate_truth_sequencer_if.sv | 24 ++
 rtl/gate_truth_sequencer.sv | 176 +++++++++++++++++
 tb/tb_gate_truth_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_truth_sequencer_if.sv
// Run-control and result bundle between whoever requests a truth-table run
// (buttons, a test host) and the sequencer that executes it.
interface gate_truth_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            busy;
  logic            done;
  logic            result_valid;
  logic            pass;
  logic [N_IN-1:0] fail_index;

  // Requester side: issues start, observes progress and result.
  modport master (
    output start,
    input  busy, done, result_valid, pass, fail_index
  );

  // Sequencer side: accepts start, reports progress and result.
  modport slave (
    input  start,
    output busy, done, result_valid, pass, fail_index
  );
endinterface

// File: rtl/gate_truth_sequencer.sv
// Truth-table sequencer for a small combinational gate under test (GUT).
// Walks every input vector in ascending order, lets each settle for SETTLE
// cycles, samples the GUT output once per vector against EXPECTED, and
// latches pass / first-failing index. The status LED glows dimly on a pass
// and blinks at 50% on a fail.
module gate_truth_sequencer #(
  parameter int                  N_IN     = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b0111,
  parameter int                  SETTLE   = 4,
  parameter int                  DIM_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_truth_sequencer_if.slave  ctl,
  output logic [N_IN-1:0]        dut_in_o,
  input  logic                   dut_out_i,
  output logic                   led_o
);

  localparam int V  = 1 << N_IN;
  // Counter just wide enough to hold SETTLE itself.
  localparam int SW = $clog2(SETTLE + 1);

  // idx is one bit wider than the vector so V-1 compares without wrap concerns.
  localparam logic [N_IN:0] IDX_LAST    = (N_IN + 1)'(V - 1);
  localparam logic [N_IN:0] IDX_ONE     = (N_IN + 1)'(1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [DIM_BITS-1:0] DIM_ONE = DIM_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  state_e                state_q;
  logic [N_IN:0]         idx_q;
  logic [N_IN:0]         idx_d;
  logic [SW-1:0]         settle_q;
  logic                  err_q;
  logic [N_IN-1:0]       dut_in_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  result_valid_q;
  logic                  pass_q;
  logic [N_IN-1:0]       fail_index_q;
  logic [DIM_BITS-1:0]   dim_ctr_q;
  logic                  led_q;
  logic                  led_d;

  // Expected truth table unpacked bit by bit so the lookup is a plain mux.
  logic [V-1:0]          exp_tbl;
  logic                  exp_bit;
  logic                  mismatch;

  genvar gi;
  generate
    for (gi = 0; gi < V; gi++) begin : g_exp
      assign exp_tbl[gi] = EXPECTED[gi];
    end
  endgenerate

  // Only the low N_IN bits address the table; idx never exceeds V-1 in SAMPLE.
  assign exp_bit  = exp_tbl[idx_q[N_IN-1:0]];
  assign mismatch = dut_out_i ^ exp_bit;
  assign idx_d    = idx_q + IDX_ONE;

  // Run sequencer: state, vector index, settle timer, error tracking and all
  // run-related outputs are registered together in one place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      settle_q       <= '0;
      err_q          <= 1'b0;
      dut_in_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      pass_q         <= 1'b0;
      fail_index_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A held start relaunches on every IDLE cycle; no queuing elsewhere.
          if (ctl.start) begin
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
            fail_index_q   <= '0;
            err_q          <= 1'b0;
            idx_q          <= '0;
            dut_in_q       <= '0;
            settle_q       <= SETTLE_LOAD;
            busy_q         <= 1'b1;
            state_q        <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          // GUT output is deliberately not looked at while it settles.
          if (settle_q == SETTLE_ONE) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q - SETTLE_ONE;
          end
        end

        ST_SAMPLE: begin
          // Only the first mismatch is recorded.
          if (mismatch && !err_q) begin
            fail_index_q <= idx_q[N_IN-1:0];
            err_q        <= 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q    <= idx_d;
            dut_in_q <= idx_d[N_IN-1:0];
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_DRIVE;
          end
        end

        ST_DONE: begin
          result_valid_q <= 1'b1;
          pass_q         <= ~err_q;
          dut_in_q       <= '0;
          state_q        <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running dimming counter; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_ctr_q <= '0;
    end else begin
      dim_ctr_q <= dim_ctr_q + DIM_ONE;
    end
  end

  // Pass: one lit cycle per counter period. Fail: MSB gives a 50% blink.
  always_comb begin
    led_d = result_valid_q &
            ((pass_q & (dim_ctr_q == '0)) | (~pass_q & dim_ctr_q[DIM_BITS-1]));
  end

  // LED is registered so it lags result_valid / dim_ctr by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign dut_in_o         = dut_in_q;
  assign led_o            = led_q;
  assign ctl.busy         = busy_q;
  assign ctl.done         = done_q;
  assign ctl.result_valid = result_valid_q;
  assign ctl.pass         = pass_q;
  assign ctl.fail_index   = fail_index_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: a behavioural GUT (lookup table plus
// optional glitching) drives dut_out, and expected results come from a
// first-mismatch model of the truth tables.
module tb_gate_truth_sequencer;

  localparam int N_IN   = 2;
  localparam int V      = 4;
  localparam int SETTLE = 4;
  localparam int PER    = SETTLE + 1;   // cycles per vector
  localparam int RUNLEN = V * PER;      // busy cycles per run
  localparam logic [3:0] EXP_TBL = 4'b0111;
  localparam int NOBS   = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       led;
  logic [3:0] gut_tbl = EXP_TBL;
  logic       glitch = 1'b0;

  gate_truth_sequencer_if #(.N_IN(N_IN)) ctl_if ();

  gate_truth_sequencer #(
    .N_IN    (N_IN),
    .EXPECTED(EXP_TBL),
    .SETTLE  (SETTLE),
    .DIM_BITS(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctl      (ctl_if),
    .dut_in_o (dut_in),
    .dut_out_i(dut_out),
    .led_o    (led)
  );

  always #5 clk = ~clk;

  // Behavioural gate under test.
  assign dut_out = gut_tbl[dut_in] ^ glitch;

  int n_cmp = 0;
  int n_bad = 0;

  logic       obs_busy [NOBS];
  logic       obs_done [NOBS];
  logic       obs_rv   [NOBS];
  logic       obs_led  [NOBS];
  logic [1:0] obs_din  [NOBS];

  // Reference: a run passes iff the gate's table equals EXPECTED; the
  // reported index is the lowest differing vector (0 on a pass).
  function automatic void ref_result(input logic [3:0] tbl,
                                     output logic p, output logic [1:0] fi);
    p  = 1'b1;
    fi = 2'd0;
    for (int v = V - 1; v >= 0; v--) begin
      if (tbl[v] != EXP_TBL[v]) begin
        p  = 1'b0;
        fi = 2'(v);
      end
    end
  endfunction

  // Issue start just before an edge, hold it for 'hold' cycles, and record
  // ncyc observations (index k = k-th cycle after the launching edge).
  task automatic run_seq(input int ncyc, input int hold, input bit glitch_en);
    @(negedge clk);
    ctl_if.start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k >= hold - 1) ctl_if.start = 1'b0;
      // Toggle the GUT output every other cycle except on sample cycles.
      glitch = glitch_en && ((k % PER) != PER - 1) && ((k % 2) == 1);
      obs_busy[k] = ctl_if.busy;
      obs_done[k] = ctl_if.done;
      obs_rv[k]   = ctl_if.result_valid;
      obs_led[k]  = led;
      obs_din[k]  = dut_in;
    end
    glitch = 1'b0;
    ctl_if.start = 1'b0;
  endtask

  task automatic count_led(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (led) hi++;
    end
  endtask

  task automatic first_done(input int ncyc, output int dk);
    dk = -1;
    for (int k = 0; k < ncyc; k++) if (obs_done[k] && dk < 0) dk = k;
  endtask

  task automatic test_reset();
    ctl_if.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ctl_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", ctl_if.busy); end
    n_cmp++; if (ctl_if.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", ctl_if.done); end
    n_cmp++; if (ctl_if.result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rv got %b want 0", ctl_if.result_valid); end
    n_cmp++; if (ctl_if.pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass got %b want 0", ctl_if.pass); end
    n_cmp++; if (ctl_if.fail_index !== 2'd0) begin n_bad++; $display("FAIL reset_fidx got %0d want 0", ctl_if.fail_index); end
    n_cmp++; if (dut_in !== 2'd0) begin n_bad++; $display("FAIL reset_dut_in got %0d want 0", dut_in); end
    n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL reset_led got %b want 0", led); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ctl_if.busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset busy got %b want 0", ctl_if.busy); end
    $display("reset: outputs idle");
  endtask

  task automatic test_ideal_nand();
    int dk, nb, hi;
    gut_tbl = EXP_TBL;
    run_seq(30, 1, 1'b0);
    first_done(30, dk);
    nb = 0;
    for (int k = 0; k < 30; k++) if (obs_busy[k]) nb++;
    n_cmp++; if (dk != RUNLEN) begin n_bad++; $display("FAIL ideal_done_cycle got %0d want %0d", dk, RUNLEN); end
    n_cmp++; if (nb != RUNLEN || obs_busy[0] !== 1'b1 || obs_busy[RUNLEN-1] !== 1'b1)
      begin n_bad++; $display("FAIL ideal_busy count %0d first %b last %b want %0d/1/1", nb, obs_busy[0], obs_busy[RUNLEN-1], RUNLEN); end
    for (int k = 0; k < RUNLEN; k++) begin
      n_cmp++;
      if (obs_din[k] !== 2'(k / PER)) begin n_bad++; $display("FAIL ideal_dut_in k=%0d got %0d want %0d", k, obs_din[k], k / PER); end
    end
    n_cmp++; if (obs_din[RUNLEN+1] !== 2'd0) begin n_bad++; $display("FAIL ideal_dut_in_after got %0d want 0", obs_din[RUNLEN+1]); end
    n_cmp++; if (obs_rv[0] !== 1'b0 || obs_rv[RUNLEN] !== 1'b0 || obs_rv[RUNLEN+1] !== 1'b1)
      begin n_bad++; $display("FAIL ideal_rv got %b%b%b want 001", obs_rv[0], obs_rv[RUNLEN], obs_rv[RUNLEN+1]); end
    n_cmp++; if (ctl_if.pass !== 1'b1 || ctl_if.fail_index !== 2'd0)
      begin n_bad++; $display("FAIL ideal_result pass %b fidx %0d want 1/0", ctl_if.pass, ctl_if.fail_index); end
    count_led(256, hi);
    n_cmp++; if (hi != 1) begin n_bad++; $display("FAIL ideal_led_duty got %0d want 1 per 256", hi); end
    $display("ideal_nand: done@%0d pass=%b fidx=%0d led_hi=%0d", dk, ctl_if.pass, ctl_if.fail_index, hi);
  endtask

  task automatic test_stuck(input logic val);
    int dk, hi;
    logic ep; logic [1:0] ef;
    gut_tbl = {4{val}};
    ref_result(gut_tbl, ep, ef);
    run_seq(30, 1, 1'b0);
    first_done(30, dk);
    n_cmp++; if (dk != RUNLEN) begin n_bad++; $display("FAIL stuck%0b_done got %0d want %0d", val, dk, RUNLEN); end
    n_cmp++; if (ctl_if.pass !== ep) begin n_bad++; $display("FAIL stuck%0b_pass got %b want %b", val, ctl_if.pass, ep); end
    n_cmp++; if (ctl_if.fail_index !== ef) begin n_bad++; $display("FAIL stuck%0b_fidx got %0d want %0d", val, ctl_if.fail_index, ef); end
    n_cmp++; if (ctl_if.result_valid !== 1'b1) begin n_bad++; $display("FAIL stuck%0b_rv got %b want 1", val, ctl_if.result_valid); end
    hi = -1;
    if (val) begin
      count_led(256, hi);
      n_cmp++; if (hi != 128) begin n_bad++; $display("FAIL stuck1_led_blink got %0d want 128 per 256", hi); end
    end
    $display("stuck%0b: pass=%b fidx=%0d led_hi=%0d", val, ctl_if.pass, ctl_if.fail_index, hi);
  endtask

  task automatic test_glitch();
    int dk;
    gut_tbl = EXP_TBL;
    run_seq(30, 1, 1'b1);
    first_done(30, dk);
    n_cmp++; if (dk != RUNLEN) begin n_bad++; $display("FAIL glitch_done got %0d want %0d", dk, RUNLEN); end
    n_cmp++; if (ctl_if.pass !== 1'b1 || ctl_if.fail_index !== 2'd0)
      begin n_bad++; $display("FAIL glitch_result pass %b fidx %0d want 1/0", ctl_if.pass, ctl_if.fail_index); end
    $display("glitch: pass=%b fidx=%0d", ctl_if.pass, ctl_if.fail_index);
  endtask

  task automatic test_random();
    int dk;
    logic ep; logic [1:0] ef;
    for (int it = 0; it < 8; it++) begin
      gut_tbl = 4'($urandom_range(0, 15));
      ref_result(gut_tbl, ep, ef);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_seq(30, 1, 1'($urandom_range(0, 1)));
      first_done(30, dk);
      n_cmp++; if (dk != RUNLEN) begin n_bad++; $display("FAIL rand%0d_done got %0d want %0d", it, dk, RUNLEN); end
      n_cmp++; if (ctl_if.pass !== ep || ctl_if.fail_index !== ef)
        begin n_bad++; $display("FAIL rand%0d_result tbl=%b pass %b fidx %0d want %b/%0d", it, gut_tbl, ctl_if.pass, ctl_if.fail_index, ep, ef); end
      $display("random%0d: tbl=%b pass=%b fidx=%0d", it, gut_tbl, ctl_if.pass, ctl_if.fail_index);
    end
  endtask

  task automatic test_back_to_back();
    int nd, nled, nlate;
    gut_tbl = 4'b1111;
    run_seq(30, 1, 1'b0);         // leave a failing result behind
    gut_tbl = EXP_TBL;
    run_seq(70, 60, 1'b0);
    nd = 0; nled = 0; nlate = 0;
    for (int k = 0; k < 70; k++) if (obs_done[k]) nd++;
    for (int k = 1; k < RUNLEN; k++) if (obs_led[k]) nled++;
    for (int k = 66; k < 70; k++) if (obs_busy[k]) nlate++;
    n_cmp++; if (nd != 3) begin n_bad++; $display("FAIL b2b_done_count got %0d want 3", nd); end
    n_cmp++; if (obs_done[20] !== 1'b1 || obs_done[42] !== 1'b1 || obs_done[64] !== 1'b1)
      begin n_bad++; $display("FAIL b2b_done_pos got %b%b%b want 111", obs_done[20], obs_done[42], obs_done[64]); end
    n_cmp++; if (obs_busy[21] !== 1'b0 || obs_busy[22] !== 1'b1)
      begin n_bad++; $display("FAIL b2b_relaunch busy21 %b busy22 %b want 0/1", obs_busy[21], obs_busy[22]); end
    n_cmp++; if (obs_rv[0] !== 1'b0 || obs_rv[21] !== 1'b1 || obs_rv[22] !== 1'b0)
      begin n_bad++; $display("FAIL b2b_rv got %b%b%b want 010", obs_rv[0], obs_rv[21], obs_rv[22]); end
    n_cmp++; if (nled != 0) begin n_bad++; $display("FAIL b2b_led_during_run got %0d lit want 0", nled); end
    n_cmp++; if (nlate != 0) begin n_bad++; $display("FAIL b2b_no_extra_run got %0d busy want 0", nlate); end
    n_cmp++; if (ctl_if.pass !== 1'b1) begin n_bad++; $display("FAIL b2b_pass got %b want 1", ctl_if.pass); end
    $display("back_to_back: dones=%0d pass=%b", nd, ctl_if.pass);
  endtask

  task automatic test_async_reset();
    int nb, dk;
    gut_tbl = 4'b1111;
    @(negedge clk);
    ctl_if.start = 1'b1;
    @(negedge clk);
    ctl_if.start = 1'b0;
    repeat (12) @(negedge clk);   // now inside vector 2
    n_cmp++; if (dut_in !== 2'd2 || ctl_if.busy !== 1'b1)
      begin n_bad++; $display("FAIL arst_pre dut_in %0d busy %b want 2/1", dut_in, ctl_if.busy); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (ctl_if.busy !== 1'b0 || dut_in !== 2'd0 || ctl_if.done !== 1'b0 || led !== 1'b0)
      begin n_bad++; $display("FAIL arst_immediate busy %b dut_in %0d done %b led %b want 0", ctl_if.busy, dut_in, ctl_if.done, led); end
    n_cmp++; if (ctl_if.result_valid !== 1'b0 || ctl_if.pass !== 1'b0 || ctl_if.fail_index !== 2'd0)
      begin n_bad++; $display("FAIL arst_result rv %b pass %b fidx %0d want 0", ctl_if.result_valid, ctl_if.pass, ctl_if.fail_index); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ctl_if.busy || dut_in != 2'd0) nb++;
    end
    n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL arst_quiet got %0d active cycles want 0", nb); end
    gut_tbl = EXP_TBL;
    run_seq(30, 1, 1'b0);
    first_done(30, dk);
    n_cmp++; if (dk != RUNLEN || ctl_if.pass !== 1'b1)
      begin n_bad++; $display("FAIL arst_rerun done %0d pass %b want %0d/1", dk, ctl_if.pass, RUNLEN); end
    $display("async_reset: rerun done@%0d pass=%b", dk, ctl_if.pass);
  endtask

  initial begin
    ctl_if.start = 1'b0;
    test_reset();
    test_ideal_nand();
    test_stuck(1'b1);
    test_stuck(1'b0);
    test_glitch();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
